// File: rtl/cnt_ctrl_pkg.sv
// Shared types and helpers for the 8-bit run/pause counter controller.
// Optional feature macro used by the top: CNT_AUTOSTOP_EN.
package cnt_ctrl_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // One count step in the requested direction, wrapping modulo 2**CNT_W.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                input logic up);
    return up ? (cnt + CNT_W'(1)) : (cnt - CNT_W'(1));
  endfunction

  // True when the next step in the requested direction would wrap.
  function automatic logic cnt_at_wrap(input logic [CNT_W-1:0] cnt,
                                       input logic up);
    return up ? (cnt == CNT_MAX) : (cnt == '0);
  endfunction

endpackage

// File: rtl/cnt8_run_ctrl_btn_debounce.sv
// Button conditioning: 2-flop synchroniser, stable-high debouncer and a
// single-cycle pulse per accepted press. A button already high when reset
// releases must be seen low once before any press is accepted.
module btn_debounce #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [1:0]    fill_q, fill_d;
  logic          armed_q, armed_d;
  logic          accepted_q, accepted_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // Synchroniser, pipeline-fill tracker and debounce state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      fill_q     <= 2'b00;
      armed_q    <= 1'b0;
      accepted_q <= 1'b0;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
    end else begin
      sync1_q    <= btn_i;
      sync2_q    <= sync1_q;
      fill_q     <= fill_d;
      armed_q    <= armed_d;
      accepted_q <= accepted_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
    end
  end

  // Count consecutive high samples; fire once when the run reaches DEB_CYCLES.
  // sync2_q only reflects the pin once fill_q[1] is set, so arming waits for it.
  always_comb begin
    fill_d     = {fill_q[0], 1'b1};
    armed_d    = armed_q | (fill_q[1] & ~sync2_q);
    cnt_d      = cnt_q;
    accepted_d = accepted_q;
    pulse_d    = 1'b0;
    if (!sync2_q) begin
      cnt_d      = '0;
      accepted_d = 1'b0;
    end else if (armed_q && !accepted_q) begin
      if (cnt_q == CNT_LAST) begin
        pulse_d    = 1'b1;
        accepted_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/cnt8_run_ctrl.sv
// 8-bit up/down counter with start/pause/clear buttons and a tick divider.
// Define CNT_AUTOSTOP_EN to make a wrapping tick hold q and drop to PAUSE.
//
// state | meaning
// IDLE  | stopped, q cleared
// RUN   | q steps on every tick
// PAUSE | q held, start resumes, stop clears
module cnt8_run_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int F_CLK_HZ   = 50_000_000,
  parameter int TICK_HZ    = 4,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_start,
  input  logic             btn_stop,
  input  logic             btn_dir,
  output logic [CNT_W-1:0] q,
  output logic             running,
  output logic             dir_up,
  output logic [1:0]       state
);

  localparam int DIV   = F_CLK_HZ / TICK_HZ;
  localparam int DIV_W = ($clog2(DIV) > 0) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic start_p, stop_p, dir_p;
  logic [DIV_W-1:0] div_q;
  logic             tick;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] q_q, q_d;
  logic             dir_q, dir_d;
  logic             running_q;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(btn_start), .pulse_o(start_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_stop (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(btn_stop), .pulse_o(stop_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(btn_dir), .pulse_o(dir_p)
  );

  // Free-running tick divider: down-counter reloading at terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (div_q == '0) begin
      div_q <= DIV_LAST;
    end else begin
      div_q <= div_q - DIV_W'(1);
    end
  end

  assign tick = (div_q == '0);

  // FSM, count and direction registers; running is registered from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      q_q       <= '0;
      dir_q     <= 1'b1;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      dir_q     <= dir_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  // Next state and count. Stop outranks start; a button edge consumes the
  // cycle so a coincident tick does not step. Steps use the old direction.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    dir_d   = dir_q ^ dir_p;
    case (state_q)
      ST_IDLE: begin
        if (!stop_p && start_p) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop_p) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
`ifdef CNT_AUTOSTOP_EN
          if (cnt_at_wrap(q_q, dir_q)) begin
            state_d = ST_PAUSE;
          end else begin
            q_d = cnt_step(q_q, dir_q);
          end
`else
          q_d = cnt_step(q_q, dir_q);
`endif
        end
      end
      ST_PAUSE: begin
        if (stop_p) begin
          state_d = ST_IDLE;
          q_d     = '0;
        end else if (start_p) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign q       = q_q;
  assign running = running_q;
  assign dir_up  = dir_q;
  assign state   = state_q;

endmodule

// File: tb/tb_cnt8_run_ctrl.sv
// Self-checking bench for cnt8_run_ctrl (F_CLK_HZ=100, TICK_HZ=10, DEB_CYCLES=4).
// Expected counts are queued as stimulus is applied and popped at each step.
module tb_cnt8_run_ctrl;

  localparam int TICK_CYC = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_stop = 1'b0;
  logic       btn_dir = 1'b0;
  logic [7:0] q;
  logic       running;
  logic       dir_up;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  cnt8_run_ctrl #(
    .F_CLK_HZ(100), .TICK_HZ(10), .DEB_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_stop(btn_stop),
    .btn_dir(btn_dir), .q(q), .running(running), .dir_up(dir_up), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  task automatic press(input logic s, input logic p, input logic d, input int cyc);
    @(negedge clk);
    btn_start = s; btn_stop = p; btn_dir = d;
    repeat (cyc) @(negedge clk);
    btn_start = 1'b0; btn_stop = 1'b0; btn_dir = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; btn_start = 1'b0; btn_stop = 1'b0; btn_dir = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // Pops one expected value per observed change of q; also checks tick spacing.
  task automatic drain();
    logic [7:0] prev, e;
    int cyc;
    bit first = 1'b1;
    while (exp_q.size() > 0) begin
      prev = q;
      cyc = 0;
      while (q === prev && cyc < 3 * TICK_CYC) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (q === prev) begin
        errors++;
        $display("FAIL step_timeout got q=%0d expected %0d", q, exp_q[0]);
        exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        if (q !== e) begin
          errors++;
          $display("FAIL step_value got %0d expected %0d", q, e);
        end
        if (!first) begin
          checks++;
          if (cyc != TICK_CYC) begin
            errors++;
            $display("FAIL tick_period got %0d expected %0d", cyc, TICK_CYC);
          end
        end
        first = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks += 4;
    if (q !== 8'd0)     begin errors++; $display("FAIL rst_q got %0d expected 0", q); end
    if (state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d expected 0", state); end
    if (dir_up !== 1'b1) begin errors++; $display("FAIL rst_dir got %0d expected 1", dir_up); end
    if (running !== 1'b0) begin errors++; $display("FAIL rst_running got %0d expected 0", running); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL post_rst_state got %0d expected 0", state); end
  endtask

  task automatic test_debounce();
    press(1'b1, 1'b0, 1'b0, 3);
    repeat (10) @(negedge clk);
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL deb_short got %0d expected 0", state); end
    press(1'b1, 1'b0, 1'b0, 6);
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL deb_early got %0d expected 0", state); end
    @(negedge clk);
    checks += 2;
    if (state !== 2'd1) begin errors++; $display("FAIL deb_run got %0d expected 1", state); end
    if (running !== 1'b1) begin errors++; $display("FAIL deb_running got %0d expected 1", running); end
    press(1'b0, 1'b1, 1'b0, 20);
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL deb_one_pulse got %0d expected 2", state); end
    press(1'b0, 1'b1, 1'b0, 6);
    @(negedge clk);
    checks += 2;
    if (state !== 2'd0) begin errors++; $display("FAIL pause_stop_state got %0d expected 0", state); end
    if (q !== 8'd0)     begin errors++; $display("FAIL pause_stop_q got %0d expected 0", q); end
  endtask

  task automatic test_pause_resume();
    press(1'b1, 1'b0, 1'b0, 6);
    for (int v = 1; v <= 5; v++) exp_q.push_back(8'(v));
    drain();
    press(1'b0, 1'b1, 1'b0, 6);
    @(negedge clk);
    checks += 3;
    if (state !== 2'd2) begin errors++; $display("FAIL pause_state got %0d expected 2", state); end
    if (q !== 8'd5)     begin errors++; $display("FAIL pause_q got %0d expected 5", q); end
    if (running !== 1'b0) begin errors++; $display("FAIL pause_running got %0d expected 0", running); end
    repeat (5 * TICK_CYC) @(negedge clk);
    checks++;
    if (q !== 8'd5) begin errors++; $display("FAIL pause_hold got %0d expected 5", q); end
    press(1'b1, 1'b0, 1'b0, 6);
    @(negedge clk);
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL resume_state got %0d expected 1", state); end
    for (int v = 6; v <= 10; v++) exp_q.push_back(8'(v));
    drain();
  endtask

  task automatic test_simultaneous();
    // q just became 10; time the stop pulse to land on the next tick edge.
    repeat (2) @(negedge clk);
    press(1'b0, 1'b1, 1'b0, 6);
    @(negedge clk);
    checks += 2;
    if (state !== 2'd2) begin errors++; $display("FAIL stop_tick_state got %0d expected 2", state); end
    if (q !== 8'd10)    begin errors++; $display("FAIL stop_tick_q got %0d expected 10", q); end
    repeat (3 * TICK_CYC) @(negedge clk);
    checks++;
    if (q !== 8'd10) begin errors++; $display("FAIL stop_tick_hold got %0d expected 10", q); end
    press(1'b1, 1'b1, 1'b0, 6);
    @(negedge clk);
    checks += 2;
    if (state !== 2'd0) begin errors++; $display("FAIL start_stop_state got %0d expected 0", state); end
    if (q !== 8'd0)     begin errors++; $display("FAIL start_stop_q got %0d expected 0", q); end
  endtask

  task automatic test_reset_mid_run();
    press(1'b1, 1'b0, 1'b0, 6);
    for (int v = 1; v <= 37; v++) exp_q.push_back(8'(v));
    drain();
    press(1'b0, 1'b0, 1'b1, 6);
    @(negedge clk);
    checks += 2;
    if (dir_up !== 1'b0) begin errors++; $display("FAIL mid_dir got %0d expected 0", dir_up); end
    if (q !== 8'd37)     begin errors++; $display("FAIL mid_q got %0d expected 37", q); end
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (q !== 8'd0)       begin errors++; $display("FAIL async_rst_q got %0d expected 0", q); end
    if (state !== 2'd0)   begin errors++; $display("FAIL async_rst_state got %0d expected 0", state); end
    if (dir_up !== 1'b1)  begin errors++; $display("FAIL async_rst_dir got %0d expected 1", dir_up); end
    if (running !== 1'b0) begin errors++; $display("FAIL async_rst_running got %0d expected 0", running); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4 * TICK_CYC) @(negedge clk);
    checks += 2;
    if (q !== 8'd0)     begin errors++; $display("FAIL rst_idle_q got %0d expected 0", q); end
    if (state !== 2'd0) begin errors++; $display("FAIL rst_idle_state got %0d expected 0", state); end
  endtask

  task automatic test_held_reset();
    @(negedge clk);
    rst_n = 1'b0;
    btn_start = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL held_start got %0d expected 0", state); end
    btn_start = 1'b0;
    repeat (5) @(negedge clk);
    press(1'b1, 1'b0, 1'b0, 6);
    @(negedge clk);
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL repress_start got %0d expected 1", state); end
  endtask

  task automatic test_wrap_down();
    apply_reset();
    press(1'b1, 1'b0, 1'b0, 6);
    exp_q.push_back(8'd1);
    drain();
    press(1'b0, 1'b0, 1'b1, 6);
`ifdef CNT_AUTOSTOP_EN
    exp_q.push_back(8'd0);
    drain();
    repeat (TICK_CYC + 2) @(negedge clk);
    checks += 2;
    if (state !== 2'd2) begin errors++; $display("FAIL autostop_down_state got %0d expected 2", state); end
    if (q !== 8'd0)     begin errors++; $display("FAIL autostop_down_q got %0d expected 0", q); end
`else
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd255);
    drain();
    checks++;
    if (dir_up !== 1'b0) begin errors++; $display("FAIL wrap_down_dir got %0d expected 0", dir_up); end
`endif
  endtask

  task automatic test_wrap_up();
    apply_reset();
    press(1'b1, 1'b0, 1'b0, 6);
    for (int v = 1; v <= 255; v++) exp_q.push_back(8'(v));
`ifdef CNT_AUTOSTOP_EN
    drain();
    repeat (TICK_CYC + 2) @(negedge clk);
    checks += 3;
    if (state !== 2'd2)   begin errors++; $display("FAIL autostop_up_state got %0d expected 2", state); end
    if (q !== 8'd255)     begin errors++; $display("FAIL autostop_up_q got %0d expected 255", q); end
    if (running !== 1'b0) begin errors++; $display("FAIL autostop_up_running got %0d expected 0", running); end
`else
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd1);
    drain();
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL wrap_up_state got %0d expected 1", state); end
`endif
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_pause_resume();
    test_simultaneous();
    test_reset_mid_run();
    test_held_reset();
    test_wrap_down();
    test_wrap_up();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
